writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Parametrised registered RISC-V writeback stage; successor to the fixed 2-way writeback.
//  Selects the result from NUM_SRC sources (ALU, load data, PC+4, immediate).
//  Aligns and sign- or zero-extends sub-word loads.
//  Carries a valid bit with stall/flush control and drives the register-file write port
//  plus the forwarding path. Sits between the memory-stage pipeline register and the register file.
// PARAMETERS
//  XLEN        32  datapath width (32 or 64)
//  REG_ADDR_W  5   register index width
//  NUM_SRC     4   result sources; 2..4 (0=ALU, 1=MEM, 2=PC+4, 3=IMM)
//  CNT_W       64  retire counter width (used only with WB_RETIRE_CNT_EN)
// PORTS
//  clk           in   1                  clock, rising edge
//  rst           in   1                  reset, asynchronous, active-high
//  valid_i       in   1                  instruction present from memory stage
//  stall_i       in   1                  hazard-unit hold; register keeps its contents
//  flush_i       in   1                  kill the instruction being captured
//  ready_o       out  1                  stage accepts input this cycle (= !stall_i)
//  reg_write_i   in   1                  instruction writes rd
//  result_src_i  in   $clog2(NUM_SRC)    result source select
//  load_type_i   in   3                  funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5
//  alu_result_i  in   XLEN               ALU result / load address
//  read_data_i   in   XLEN               raw word from data memory
//  pc_plus4_i    in   XLEN               link value
//  imm_i         in   XLEN               immediate (LUI)
//  rd_i          in   REG_ADDR_W         destination register
//  valid_o       out  1                  registered instruction valid
//  reg_write_o   out  1                  register-file write enable
//  rd_o          out  REG_ADDR_W         register-file write address
//  result_o      out  XLEN               register-file write data / forward value
//  retire_cnt_o  out  CNT_W              retired-instruction count (WB_RETIRE_CNT_EN only)
// BEHAVIOUR
//  - Reset: valid_o, reg_write_o, rd_o, result_o and retire_cnt_o all 0; takes effect
//    asynchronously at any time, including with a stall pending.
//  - Latency: 1 cycle. Inputs are captured on the rising clk edge when stall_i=0.
//  - stall_i=1: all outputs hold; inputs are ignored; ready_o=0.
//  - flush_i=1 with stall_i=0: valid_o<=0, reg_write_o<=0; rd_o and result_o load normally.
//  - flush_i=1 with stall_i=1: flush wins; valid_o and reg_write_o clear, the rest hold.
//  - reg_write_o <= valid_i & reg_write_i & (rd_i != 0); writes to x0 are never issued.
//  - Load align: off = alu_result_i[1:0] (XLEN=64 uses [2:0]).
//    - LB/LBU: byte at off.
//    - LH/LHU: halfword at off[MSB:1]; off[0] is ignored.
//    - LW: word (word select from off[2] when XLEN=64).
//    - Sign extension for LB/LH; zero extension for LBU/LHU.
//    - Any other funct3 passes read_data_i through unchanged.
//  - Source mux: result_src_i >= NUM_SRC selects the ALU result.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined:
//    - retire_cnt_o increments by 1 on each edge with valid_i & !flush_i & !stall_i.
//    - Wraps to 0 after 2^CNT_W-1.
//  WB_RETIRE_CNT_EN undefined: retire_cnt_o port and counter are absent.
// STRUCTURE
//  Package wb_pkg:
//    - result_src_e enum (SRC_ALU, SRC_MEM, SRC_PC4, SRC_IMM)
//    - load_type_e enum (funct3 encodings above)
//  Sub-module wb_load_align (combinational): read_data + offset + load_type -> extended value.
//  Top level: source mux plus one pipeline register.
// TESTING
//  1. rst=1 mid-stream -> all outputs 0 immediately; rst released, valid_i=1 ALU 0x1234 rd=5
//     -> next cycle result_o=0x1234, rd_o=5, reg_write_o=1.
//  2. LB, off=3, read_data_i=0x80FF_0000 -> result_o=0xFFFF_FF80.
//     LBU, same inputs -> result_o=0x0000_0080.
//  3. LH, off=2, read_data_i=0x8001_1234 -> result_o=0xFFFF_8001.
//     LHU -> result_o=0x0000_8001.
//  4. reg_write_i=1, rd_i=0 -> reg_write_o=0, valid_o=1.
//     result_src_i=2, pc_plus4_i=0x104 -> result_o=0x104.
//  5. stall_i=1 for 3 cycles with changing inputs -> outputs frozen.
//     flush_i=1 during stall -> valid_o=0, reg_write_o=0.
//  6. WB_RETIRE_CNT_EN, 10 valid instructions with 2 flushed and 1 stalled cycle -> retire_cnt_o=8.
//     CNT_W=4 preload 15, one valid instruction -> retire_cnt_o wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source and load-type encodings.
// The retire counter is built only when WB_RETIRE_CNT_EN is defined.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2,
        SRC_IMM = 2'd3
    } result_src_e;

    typedef enum logic [2:0] {
        LT_LB  = 3'd0,
        LT_LH  = 3'd1,
        LT_LW  = 3'd2,
        LT_LBU = 3'd4,
        LT_LHU = 3'd5
    } load_type_e;

    function automatic int unsigned src_sel_w(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Bus between the memory-stage register and the writeback stage, plus the register-file port.
// master drives the instruction fields; slave is the writeback stage.
interface wb_if
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 4
);
    localparam int SRC_W = src_sel_w(NUM_SRC);

    logic                  valid_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  ready_o;
    logic                  reg_write_i;
    logic [SRC_W-1:0]      result_src_i;
    logic [2:0]            load_type_i;
    logic [XLEN-1:0]       alu_result_i;
    logic [XLEN-1:0]       read_data_i;
    logic [XLEN-1:0]       pc_plus4_i;
    logic [XLEN-1:0]       imm_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  valid_o;
    logic                  reg_write_o;
    logic [REG_ADDR_W-1:0] rd_o;
    logic [XLEN-1:0]       result_o;

    modport master (
        output valid_i, stall_i, flush_i, reg_write_i, result_src_i, load_type_i,
               alu_result_i, read_data_i, pc_plus4_i, imm_i, rd_i,
        input  ready_o, valid_o, reg_write_o, rd_o, result_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, reg_write_i, result_src_i, load_type_i,
               alu_result_i, read_data_i, pc_plus4_i, imm_i, rd_i,
        output ready_o, valid_o, reg_write_o, rd_o, result_o
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational sub-word load alignment: picks the byte/half/word addressed by the low
// address bits and sign- or zero-extends it; unknown funct3 passes the raw word through.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  read_data_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       load_type_i,
    output logic [XLEN-1:0]  load_val_o
);
    localparam int SH_W = OFF_W + 3;

    logic [SH_W-1:0] byte_sh;
    logic [SH_W-1:0] half_sh;
    logic [SH_W-1:0] word_sh;
    logic [XLEN-1:0] byte_data;
    logic [XLEN-1:0] half_data;
    logic [XLEN-1:0] word_data;

    always_comb begin
        byte_sh = {off_i, 3'b000};
        // Halfword accesses ignore the low offset bit.
        half_sh = {off_i[OFF_W-1:1], 4'b0000};
        word_sh = '0;
        if (XLEN == 64) begin
            word_sh = {off_i[OFF_W-1], {(SH_W-1){1'b0}}};
        end
        byte_data = read_data_i >> byte_sh;
        half_data = read_data_i >> half_sh;
        word_data = read_data_i >> word_sh;
    end

    always_comb begin
        load_val_o = read_data_i;
        case (load_type_i)
            LT_LB:   load_val_o = XLEN'($signed(byte_data[7:0]));
            LT_LH:   load_val_o = XLEN'($signed(half_data[15:0]));
            LT_LW:   load_val_o = XLEN'($signed(word_data[31:0]));
            LT_LBU:  load_val_o = XLEN'(byte_data[7:0]);
            LT_LHU:  load_val_o = XLEN'(half_data[15:0]);
            default: load_val_o = read_data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: source mux, load alignment and one pipeline register with
// stall/flush. Optional retired-instruction counter when WB_RETIRE_CNT_EN is defined.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 4,
    parameter int CNT_W      = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_if.slave             bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt_o
`endif
);
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic [XLEN-1:0]       load_val;
    logic [XLEN-1:0]       result_d;
    logic [1:0]            src_sel;
    logic                  reg_write_d;
    logic                  valid_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       result_q;

    wb_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .read_data_i (bus.read_data_i),
        .off_i       (bus.alu_result_i[OFF_W-1:0]),
        .load_type_i (bus.load_type_i),
        .load_val_o  (load_val)
    );

    always_comb begin
        src_sel  = 2'(bus.result_src_i);
        result_d = bus.alu_result_i;
        // Encodings beyond the configured source count fall back to the ALU.
        if (int'(bus.result_src_i) < NUM_SRC) begin
            case (result_src_e'(src_sel))
                SRC_MEM: result_d = load_val;
                SRC_PC4: result_d = bus.pc_plus4_i;
                SRC_IMM: result_d = bus.imm_i;
                default: result_d = bus.alu_result_i;
            endcase
        end
    end

    assign reg_write_d = bus.valid_i & bus.reg_write_i & (bus.rd_i != '0) & ~bus.flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
        end else if (bus.stall_i) begin
            // A flush during a stall kills the held instruction but keeps its data.
            if (bus.flush_i) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
            end
        end else begin
            valid_q     <= bus.valid_i & ~bus.flush_i;
            reg_write_q <= reg_write_d;
            rd_q        <= bus.rd_i;
            result_q    <= result_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (bus.valid_i && !bus.flush_i && !bus.stall_i) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`endif

    assign bus.ready_o     = ~bus.stall_i;
    assign bus.valid_o     = valid_q;
    assign bus.reg_write_o = reg_write_q;
    assign bus.rd_o        = rd_q;
    assign bus.result_o    = result_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; the counter section builds only with WB_RETIRE_CNT_EN.
module tb_writeback_stage;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_if #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(4)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    logic [3:0]  retire_cnt4;
    wb_if #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(4)) bus4 ();

    writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(4), .CNT_W(64)) dut (
        .clk (clk), .rst (rst), .bus (bus), .retire_cnt_o (retire_cnt)
    );
    writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(4), .CNT_W(4)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4), .retire_cnt_o (retire_cnt4)
    );
`else
    writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_SRC(4), .CNT_W(64)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    task automatic idle();
        bus.valid_i      = 1'b0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.reg_write_i  = 1'b0;
        bus.result_src_i = 2'd0;
        bus.load_type_i  = 3'd0;
        bus.alu_result_i = '0;
        bus.read_data_i  = '0;
        bus.pc_plus4_i   = '0;
        bus.imm_i        = '0;
        bus.rd_i         = '0;
    endtask

    task automatic issue(input logic [1:0] src, input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd);
        bus.valid_i      = 1'b1;
        bus.reg_write_i  = 1'b1;
        bus.result_src_i = src;
        bus.load_type_i  = lt;
        bus.alu_result_i = alu;
        bus.read_data_i  = rdata;
        bus.rd_i         = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load vectors: load type, offset, raw word, expected result.
    typedef struct {
        string       tag;
        logic [2:0]  lt;
        logic [31:0] off;
        logic [31:0] rdata;
        logic [31:0] exp_v;
    } ld_vec_t;

    ld_vec_t ld_vecs[$];

    initial begin
        ld_vecs.push_back('{"lb_off3",   3'd0, 32'd3, 32'h80FF_0000, 32'hFFFF_FF80});
        ld_vecs.push_back('{"lbu_off3",  3'd4, 32'd3, 32'h80FF_0000, 32'h0000_0080});
        ld_vecs.push_back('{"lb_off2",   3'd0, 32'd2, 32'h80FF_0000, 32'hFFFF_FFFF});
        ld_vecs.push_back('{"lb_off0",   3'd0, 32'd0, 32'h80FF_0000, 32'h0000_0000});
        ld_vecs.push_back('{"lb_off1",   3'd0, 32'd1, 32'h1234_5678, 32'h0000_0056});
        ld_vecs.push_back('{"lh_off2",   3'd1, 32'd2, 32'h8001_1234, 32'hFFFF_8001});
        ld_vecs.push_back('{"lhu_off2",  3'd5, 32'd2, 32'h8001_1234, 32'h0000_8001});
        ld_vecs.push_back('{"lh_off3",   3'd1, 32'd3, 32'h8001_1234, 32'hFFFF_8001});
        ld_vecs.push_back('{"lh_off0",   3'd1, 32'd0, 32'h8001_9234, 32'hFFFF_9234});
        ld_vecs.push_back('{"lhu_off1",  3'd5, 32'd1, 32'h8001_9234, 32'h0000_9234});
        ld_vecs.push_back('{"lw",        3'd2, 32'd2, 32'hCAFE_BABE, 32'hCAFE_BABE});
        ld_vecs.push_back('{"f3_pass",   3'd3, 32'd1, 32'h8765_4321, 32'h8765_4321});

        idle();
        #1;
        check("rst_valid",  bus.valid_o,     0);
        check("rst_result", bus.result_o,    0);
        #10;
        rst = 1'b0;

        // Put something non-zero in the register, then reset asynchronously under a stall.
        issue(2'd0, 3'd0, 32'hDEAD, 32'h0, 5'd3);
        step();
        check("pre_result", bus.result_o, 32'hDEAD);
        check("pre_rd",     bus.rd_o,     3);
        bus.stall_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",  bus.valid_o,     0);
        check("arst_rw",     bus.reg_write_o, 0);
        check("arst_rd",     bus.rd_o,        0);
        check("arst_result", bus.result_o,    0);
        #1;
        rst = 1'b0;
        bus.stall_i = 1'b0;
        issue(2'd0, 3'd0, 32'h1234, 32'h0, 5'd5);
        step();
        check("alu_result", bus.result_o,    32'h1234);
        check("alu_rd",     bus.rd_o,        5);
        check("alu_rw",     bus.reg_write_o, 1);
        check("alu_valid",  bus.valid_o,     1);
        check("ready",      bus.ready_o,     1);

        foreach (ld_vecs[i]) begin
            issue(2'd1, ld_vecs[i].lt, ld_vecs[i].off, ld_vecs[i].rdata, 5'd10);
            step();
            check(ld_vecs[i].tag, bus.result_o, ld_vecs[i].exp_v);
        end

        issue(2'd0, 3'd0, 32'h77, 32'h0, 5'd0);
        step();
        check("x0_rw",    bus.reg_write_o, 0);
        check("x0_valid", bus.valid_o,     1);

        issue(2'd2, 3'd0, 32'h99, 32'h0, 5'd1);
        bus.pc_plus4_i = 32'h104;
        step();
        check("pc4_result", bus.result_o, 32'h104);

        issue(2'd3, 3'd0, 32'h99, 32'h0, 5'd2);
        bus.imm_i = 32'hABCD_E000;
        step();
        check("imm_result", bus.result_o, 32'hABCD_E000);

        issue(2'd0, 3'd0, 32'h42, 32'h0, 5'd4);
        bus.valid_i = 1'b0;
        step();
        check("inv_valid", bus.valid_o,     0);
        check("inv_rw",    bus.reg_write_o, 0);
        check("inv_rd",    bus.rd_o,        4);

        issue(2'd0, 3'd0, 32'h43, 32'h0, 5'd6);
        bus.reg_write_i = 1'b0;
        step();
        check("norw_rw",    bus.reg_write_o, 0);
        check("norw_valid", bus.valid_o,     1);

        // Stall: three cycles of changing inputs must leave the outputs frozen.
        issue(2'd0, 3'd0, 32'hAAAA, 32'h0, 5'd7);
        step();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 3'd0, 32'h1000 + 32'(i), 32'h0, 5'(20 + i));
            #1;
            check("stall_ready", bus.ready_o, 0);
            step();
            check("stall_result", bus.result_o,    32'hAAAA);
            check("stall_rd",     bus.rd_o,        7);
            check("stall_valid",  bus.valid_o,     1);
            check("stall_rw",     bus.reg_write_o, 1);
        end
        bus.flush_i = 1'b1;
        step();
        check("sflush_valid",  bus.valid_o,     0);
        check("sflush_rw",     bus.reg_write_o, 0);
        check("sflush_result", bus.result_o,    32'hAAAA);
        check("sflush_rd",     bus.rd_o,        7);

        bus.stall_i = 1'b0;
        issue(2'd0, 3'd0, 32'h55, 32'h0, 5'd9);
        step();
        check("flush_valid",  bus.valid_o,     0);
        check("flush_rw",     bus.reg_write_o, 0);
        check("flush_result", bus.result_o,    32'h55);
        check("flush_rd",     bus.rd_o,        9);
        bus.flush_i = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        idle();
        bus4.valid_i      = 1'b0;
        bus4.stall_i      = 1'b0;
        bus4.flush_i      = 1'b0;
        bus4.reg_write_i  = 1'b0;
        bus4.result_src_i = 2'd0;
        bus4.load_type_i  = 3'd0;
        bus4.alu_result_i = '0;
        bus4.read_data_i  = '0;
        bus4.pc_plus4_i   = '0;
        bus4.imm_i        = '0;
        bus4.rd_i         = '0;
        rst = 1'b1;
        #2;
        check("cnt_rst", retire_cnt, 0);
        rst = 1'b0;
        // Ten instructions (2nd and 6th flushed) plus one stalled cycle before the 4th.
        for (int i = 0; i < 11; i++) begin
            issue(2'd0, 3'd0, 32'(i), 32'h0, 5'd1);
            bus.flush_i = (i == 1 || i == 6);
            bus.stall_i = (i == 3);
            step();
        end
        idle();
        step();
        check("cnt_eight", retire_cnt, 8);

        bus4.valid_i = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("cnt4_max", 64'(retire_cnt4), 15);
        step();
        check("cnt4_wrap", 64'(retire_cnt4), 0);
        bus4.valid_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
